// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: skid-buffer occupancy state and the default data width.
package cpu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;

  // Occupancy of a skid buffer in a given state.
  function automatic logic [1:0] skid_count(skid_state_t s);
    case (s)
      ONE:     skid_count = 2'd1;
      FULL:    skid_count = 2'd2;
      default: skid_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline register. in_ready comes from the state flop only,
// so the upstream handshake never depends combinationally on out_ready.
module pipe_skid_reg
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_fire, out_fire;
  logic             load_main, load_skid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides any simultaneous transfer
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) state_d = ONE;
        ONE: begin
          if (in_fire && !out_ready)      state_d = FULL;
          else if (!in_fire && out_fire)  state_d = EMPTY;
        end
        FULL:  if (out_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output logic, driven from flops only
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != FULL);
    count     = skid_count(state_q);
  end

  // main refills from skid when draining FULL, otherwise straight from upstream
  assign load_main = !flush &&
                     (((state_q == EMPTY) && in_fire) ||
                      ((state_q == ONE)   && in_fire && out_fire) ||
                      ((state_q == FULL)  && out_fire));
  assign load_skid = !flush && (state_q == ONE) && in_fire && !out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         main_q <= '0;
    else if (load_main) main_q <= (state_q == FULL) ? skid_q : in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         skid_q <= '0;
    else if (load_skid) skid_q <= in_data;
  end

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus randomized traffic
// checked against a queue-based FIFO model of the buffer.
module tb_pipe_skid_reg;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] q[$];
  bit took;

  pipe_skid_reg #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  // Upstream obligation: an offered word stays put until it is accepted
  logic         p_v = 1'b0, p_r = 1'b0;
  logic [W-1:0] p_d = '0;
  always @(posedge clk) begin
    if (reset && p_v && !p_r)
      assert (in_valid && in_data == p_d) else $error("upstream hold violated");
    p_v = in_valid & reset;
    p_r = in_ready;
    p_d = in_data;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".out_valid"}, out_valid, q.size() != 0);
    chk({tag, ".in_ready"}, in_ready, q.size() < 2);
    chk({tag, ".count"}, count, q.size());
    if (q.size() != 0) chk({tag, ".out_data"}, out_data, q[0]);
  endtask

  // One clock with the current inputs: advance the FIFO model, then compare.
  task automatic cycle(input string tag);
    bit ov, ir;
    ov = q.size() != 0;
    ir = q.size() < 2;
    took = in_valid && ir;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (ov && out_ready) void'(q.pop_front());
      if (in_valid && ir) q.push_back(in_data);
    end
    @(negedge clk);
    cmp_model(tag);
  endtask

  task automatic drive(input string tag, input logic iv, input logic [W-1:0] d,
                       input logic ordy, input logic fl);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    cycle(tag);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    q.delete();
    chk({tag, ".rst_ov"}, out_valid, 1'b0);
    chk({tag, ".rst_ir"}, in_ready, 1'b1);
    chk({tag, ".rst_data"}, out_data, '0);
    chk({tag, ".rst_cnt"}, count, 2'd0);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit hold;
    repeat (2) @(negedge clk);
    chk("reset.out_valid", out_valid, 1'b0);
    chk("reset.in_ready", in_ready, 1'b1);
    chk("reset.out_data", out_data, '0);
    chk("reset.count", count, 2'd0);
    reset = 1'b1;

    // 1: streaming at full rate
    drive("t1a", 1, 32'h11, 1, 0); chk("t1a.data", out_data, 32'h11); chk("t1a.cnt", count, 1);
    drive("t1b", 1, 32'h22, 1, 0); chk("t1b.data", out_data, 32'h22); chk("t1b.cnt", count, 1);
    drive("t1c", 1, 32'h33, 1, 0); chk("t1c.data", out_data, 32'h33); chk("t1c.ir", in_ready, 1);
    drive("t1d", 0, 0, 1, 0);      chk("t1d.ov", out_valid, 0);

    // 2: stall fills the skid, then drains in order
    drive("t2a", 1, 32'hA0, 0, 0);
    drive("t2b", 1, 32'hA1, 0, 0); chk("t2b.cnt", count, 2); chk("t2b.ir", in_ready, 0);
    drive("t2c", 0, 0, 0, 0);      chk("t2c.data", out_data, 32'hA0); chk("t2c.ov", out_valid, 1);
    drive("t2d", 0, 0, 1, 0);      chk("t2d.data", out_data, 32'hA1); chk("t2d.cnt", count, 1);
    drive("t2e", 0, 0, 1, 0);      chk("t2e.cnt", count, 0);

    // 3: FULL with a third word waiting upstream
    drive("t3a", 1, 32'hB0, 0, 0);
    drive("t3b", 1, 32'hB1, 0, 0); chk("t3b.data", out_data, 32'hB0);
    drive("t3c", 1, 32'hB2, 1, 0); chk("t3c.data", out_data, 32'hB1); chk("t3c.cnt", count, 1);
    drive("t3d", 1, 32'hB2, 1, 0); chk("t3d.data", out_data, 32'hB2); chk("t3d.cnt", count, 1);
    drive("t3e", 0, 0, 1, 0);      chk("t3e.cnt", count, 0);

    // 4: flush from FULL
    drive("t4a", 1, 32'hD0, 0, 0);
    drive("t4b", 1, 32'hD1, 0, 0);
    drive("t4c", 0, 0, 1, 1);      chk("t4c.ov", out_valid, 0); chk("t4c.cnt", count, 0); chk("t4c.ir", in_ready, 1);
    drive("t4d", 0, 0, 1, 0);      chk("t4d.ov", out_valid, 0);

    // 5: word offered during flush is dropped
    drive("t5a", 1, 32'hC0, 0, 0); chk("t5a.data", out_data, 32'hC0);
    drive("t5b", 1, 32'hC1, 0, 1); chk("t5b.ov", out_valid, 0);
    drive("t5c", 0, 0, 1, 0);      chk("t5c.ov", out_valid, 0); chk("t5c.cnt", count, 0);

    // 6: asynchronous reset while FULL
    drive("t6a", 1, 32'hE0, 0, 0);
    drive("t6b", 1, 32'hE1, 0, 0); chk("t6b.cnt", count, 2);
    async_reset("t6");
    cmp_model("t6.post");

    // Randomized traffic with flushes and occasional mid-run resets
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        in_valid = ($urandom_range(3) != 0);
        in_data  = $urandom;
      end
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(40) == 0);
      cycle("rnd");
      hold = in_valid && !took;
      if ($urandom_range(400) == 0) begin
        async_reset("rnd");
        hold = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
